// File: rtl/alu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_pkg : opcodes, FSM state encoding and opcode legality check   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
package alu_pkg;

  localparam logic [2:0] OP_AND   = 3'd0;
  localparam logic [2:0] OP_OR    = 3'd1;
  localparam logic [2:0] OP_ADD   = 3'd2;
  localparam logic [2:0] OP_LOADI = 3'd3;
  localparam logic [2:0] OP_SUB   = 3'd6;
  localparam logic [2:0] OP_SLT   = 3'd7;

  localparam int REG_IDX_W = 2;
  localparam int DATA_W    = 4;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_READ = 2'd1,
    S_EXEC = 2'd2,
    S_WB   = 2'd3
  } state_e;

  function automatic logic is_legal_op(input logic [2:0] op);
    return !((op == 3'd4) || (op == 3'd5));
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_issue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue_if : instruction valid/ready handshake bundle           |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
interface alu_issue_if;
  logic       instr_valid;
  logic       instr_ready;
  logic [2:0] instr_op;
  logic [1:0] instr_rd;
  logic [1:0] instr_rs;
  logic [1:0] instr_rt;
  logic [3:0] instr_imm;

  modport master (
    output instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm,
    input  instr_ready
  );

  modport slave (
    input  instr_valid, instr_op, instr_rd, instr_rs, instr_rt, instr_imm,
    output instr_ready
  );
endinterface
`default_nettype wire

// File: rtl/alu_regfile.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_regfile : 4x4 register file, R0 hardwired to zero,            |
// | two read ports, one debug read port, one synchronous write port   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_regfile
  import alu_pkg::*;
#(
  parameter int NREG = 4
) (
  input  wire logic                 clk,
  input  wire logic                 rst_n,
  input  wire logic                 we,
  input  wire logic [REG_IDX_W-1:0] waddr,
  input  wire logic [DATA_W-1:0]    wdata,
  input  wire logic [REG_IDX_W-1:0] raddr_a,
  output logic      [DATA_W-1:0]    rdata_a,
  input  wire logic [REG_IDX_W-1:0] raddr_b,
  output logic      [DATA_W-1:0]    rdata_b,
  input  wire logic [REG_IDX_W-1:0] dbg_sel,
  output logic      [DATA_W-1:0]    dbg_data
);

  logic [DATA_W-1:0] regs [NREG];

  assign regs[0] = '0;

  for (genvar i = 1; i < NREG; i++) begin : g_reg
    logic [DATA_W-1:0] reg_q;
    logic [DATA_W-1:0] reg_d;

    always_comb begin
      reg_d = reg_q;
      if (we && (waddr == REG_IDX_W'(i))) begin
        reg_d = wdata;
      end
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        reg_q <= '0;
      end else begin
        reg_q <= reg_d;
      end
    end

    assign regs[i] = reg_q;
  end

  assign rdata_a  = regs[raddr_a];
  assign rdata_b  = regs[raddr_b];
  assign dbg_data = regs[dbg_sel];

endmodule
`default_nettype wire

// File: rtl/alu_issue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_issue : sequencing front end for the external 4-bit alu.      |
// | Optional retired-instruction counter: define ALU_ISSUE_PERF_EN.   |
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module alu_issue
  import alu_pkg::*;
#(
  parameter int NREG = 4
) (
  input  wire logic       clk,
  input  wire logic       rst_n,
  alu_issue_if.slave      instr,
  output logic      [3:0] alu_a,
  output logic      [3:0] alu_b,
  output logic      [2:0] alu_op,
  output logic            alu_ci,
  output logic            alu_zero,
  input  wire logic [3:0] alu_r,
  input  wire logic       alu_co,
  input  wire logic       alu_slt,
  output logic            flag_c,
  output logic            flag_s,
  output logic            flag_z,
  output logic            wb_valid,
  output logic            err,
  input  wire logic [1:0] dbg_sel,
  output logic      [3:0] dbg_data,
  output logic      [7:0] perf_count
);

  state_e     state_q, state_d;
  logic [2:0] op_q, op_d;
  logic [1:0] rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
  logic [3:0] imm_q, imm_d;
  logic [3:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0] alu_op_q, alu_op_d;
  logic       alu_ci_q, alu_ci_d;
  logic [3:0] res_q, res_d;
  logic       co_q, co_d, slt_q, slt_d;
  logic       flag_c_q, flag_c_d, flag_s_q, flag_s_d, flag_z_q, flag_z_d;
  logic       wb_valid_q, wb_valid_d;
  logic       err_q, err_d;

  logic       wb_we;
  logic [3:0] wb_val;
  logic [3:0] rf_a, rf_b;

  alu_regfile #(.NREG(NREG)) u_regfile (
    .clk      (clk),
    .rst_n    (rst_n),
    .we       (wb_we),
    .waddr    (rd_q),
    .wdata    (wb_val),
    .raddr_a  (rs_q),
    .rdata_a  (rf_a),
    .raddr_b  (rt_q),
    .rdata_b  (rf_b),
    .dbg_sel  (dbg_sel),
    .dbg_data (dbg_data)
  );

  // SLT retires the comparison bit rather than the ALU difference
  always_comb begin
    case (op_q)
      OP_SLT:   wb_val = {3'b000, slt_q};
      OP_LOADI: wb_val = imm_q;
      default:  wb_val = res_q;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    rt_d       = rt_q;
    imm_d      = imm_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    alu_op_d   = alu_op_q;
    alu_ci_d   = alu_ci_q;
    res_d      = res_q;
    co_d       = co_q;
    slt_d      = slt_q;
    flag_c_d   = flag_c_q;
    flag_s_d   = flag_s_q;
    flag_z_d   = flag_z_q;
    wb_valid_d = 1'b0;
    err_d      = err_q;
    wb_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (instr.instr_valid) begin
          if (is_legal_op(instr.instr_op)) begin
            op_d    = instr.instr_op;
            rd_d    = instr.instr_rd;
            rs_d    = instr.instr_rs;
            rt_d    = instr.instr_rt;
            imm_d   = instr.instr_imm;
            state_d = S_READ;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_READ: begin
        alu_a_d  = rf_a;
        alu_b_d  = rf_b;
        alu_op_d = op_q;
        alu_ci_d = (op_q == OP_SUB) || (op_q == OP_SLT);
        state_d  = (op_q == OP_LOADI) ? S_WB : S_EXEC;
      end
      S_EXEC: begin
        res_d   = alu_r;
        co_d    = alu_co;
        slt_d   = alu_slt;
        state_d = S_WB;
      end
      S_WB: begin
        wb_we      = 1'b1;
        wb_valid_d = 1'b1;
        flag_z_d   = (wb_val == 4'd0);
        flag_c_d   = (op_q == OP_LOADI) ? 1'b0 : co_q;
        flag_s_d   = (op_q == OP_SLT) ? slt_q : 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      rs_q       <= '0;
      rt_q       <= '0;
      imm_q      <= '0;
      alu_a_q    <= '0;
      alu_b_q    <= '0;
      alu_op_q   <= '0;
      alu_ci_q   <= 1'b0;
      res_q      <= '0;
      co_q       <= 1'b0;
      slt_q      <= 1'b0;
      flag_c_q   <= 1'b0;
      flag_s_q   <= 1'b0;
      flag_z_q   <= 1'b0;
      wb_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      rd_q       <= rd_d;
      rs_q       <= rs_d;
      rt_q       <= rt_d;
      imm_q      <= imm_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      alu_op_q   <= alu_op_d;
      alu_ci_q   <= alu_ci_d;
      res_q      <= res_d;
      co_q       <= co_d;
      slt_q      <= slt_d;
      flag_c_q   <= flag_c_d;
      flag_s_q   <= flag_s_d;
      flag_z_q   <= flag_z_d;
      wb_valid_q <= wb_valid_d;
      err_q      <= err_d;
    end
  end

  assign instr.instr_ready = (state_q == S_IDLE);
  assign alu_a    = alu_a_q;
  assign alu_b    = alu_b_q;
  assign alu_op   = alu_op_q;
  assign alu_ci   = alu_ci_q;
  assign alu_zero = 1'b0;
  assign flag_c   = flag_c_q;
  assign flag_s   = flag_s_q;
  assign flag_z   = flag_z_q;
  assign wb_valid = wb_valid_q;
  assign err      = err_q;

`ifdef ALU_ISSUE_PERF_EN
  logic [7:0] perf_q, perf_d;

  // Saturating count of writebacks; illegal ops never reach WB
  always_comb begin
    perf_d = perf_q;
    if ((state_q == S_WB) && (perf_q != 8'hFF)) begin
      perf_d = perf_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_q <= '0;
    end else begin
      perf_q <= perf_d;
    end
  end

  assign perf_count = perf_q;
`else
  assign perf_count = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_issue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_issue : directed + random self-checking bench for alu_issue|
// | Revision: 1.0                                                     |
// +------------------------------------------------------------------+
module tb_alu_issue;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] alu_a, alu_b, alu_r, dbg_data;
  logic [2:0] alu_op;
  logic       alu_ci, alu_zero, alu_co, alu_slt;
  logic       flag_c, flag_s, flag_z, wb_valid, err;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] perf_count;
  logic [4:0] alu_sum;

  int n_checks = 0;
  int n_errors = 0;

  int m_regs [4];
  int m_perf;
  int m_err;

  always #5 clk = ~clk;

  alu_issue_if ifc ();

  alu_issue #(.NREG(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .instr      (ifc),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_ci     (alu_ci),
    .alu_zero   (alu_zero),
    .alu_r      (alu_r),
    .alu_co     (alu_co),
    .alu_slt    (alu_slt),
    .flag_c     (flag_c),
    .flag_s     (flag_s),
    .flag_z     (flag_z),
    .wb_valid   (wb_valid),
    .err        (err),
    .dbg_sel    (dbg_sel),
    .dbg_data   (dbg_data),
    .perf_count (perf_count)
  );

  // Stand-in for the downstream alu: bit-level adder with carry-in
  always_comb begin
    alu_sum = '0;
    alu_r   = '0;
    alu_co  = 1'b0;
    alu_slt = 1'b0;
    case (alu_op)
      3'd0: alu_r = alu_a & alu_b;
      3'd1: alu_r = alu_a | alu_b;
      3'd2: begin
        alu_sum = {1'b0, alu_a} + {1'b0, alu_b} + {4'b0, alu_ci};
        alu_r   = alu_sum[3:0];
        alu_co  = alu_sum[4];
      end
      3'd6, 3'd7: begin
        alu_sum = {1'b0, alu_a} + {1'b0, ~alu_b} + {4'b0, alu_ci};
        alu_r   = alu_sum[3:0];
        alu_co  = alu_sum[4];
        alu_slt = alu_r[3] ^ ((alu_a[3] != alu_b[3]) && (alu_r[3] != alu_a[3]));
      end
      default: ;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int exp_perf();
`ifdef ALU_ISSUE_PERF_EN
    return (m_perf > 255) ? 255 : m_perf;
`else
    return 0;
`endif
  endfunction

  // Reference semantics from plain integer arithmetic
  function automatic void ref_exec(input int op, input int a, input int b, input int imm,
                                   output int val, output int c, output int s);
    int sa, sb;
    val = 0; c = 0; s = 0;
    case (op)
      0: val = a & b;
      1: val = a | b;
      2: begin val = (a + b) % 16; c = ((a + b) > 15) ? 1 : 0; end
      3: val = imm;
      6: begin val = (a - b + 16) % 16; c = (a >= b) ? 1 : 0; end
      7: begin
        sa  = (a >= 8) ? a - 16 : a;
        sb  = (b >= 8) ? b - 16 : b;
        s   = (sa < sb) ? 1 : 0;
        val = s;
        c   = (a >= b) ? 1 : 0;
      end
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] legal_op(input int idx);
    case (idx)
      0: return 3'd0;
      1: return 3'd1;
      2: return 3'd2;
      3: return 3'd3;
      4: return 3'd6;
      default: return 3'd7;
    endcase
  endfunction

  task automatic check_regs();
    for (int i = 0; i < 4; i++) begin
      dbg_sel = 2'(i);
      #1;
      chk($sformatf("dbg_r%0d", i), {28'd0, dbg_data}, m_regs[i]);
    end
  endtask

  task automatic do_instr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                          input logic [1:0] rt, input logic [3:0] imm);
    int  a, b, val, c, s, cyc;
    bit  seen;
    a = m_regs[rs];
    b = m_regs[rt];
    chk("ready_idle", {31'd0, ifc.instr_ready}, 1);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = op;
    ifc.instr_rd    = rd;
    ifc.instr_rs    = rs;
    ifc.instr_rt    = rt;
    ifc.instr_imm   = imm;
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    ifc.instr_op    = 3'($urandom);
    ifc.instr_rd    = 2'($urandom);
    ifc.instr_rs    = 2'($urandom);
    ifc.instr_rt    = 2'($urandom);
    ifc.instr_imm   = 4'($urandom);
    if (op == 3'd4 || op == 3'd5) begin
      m_err = 1;
      chk("err_set", {31'd0, err}, 1);
      chk("ready_after_illegal", {31'd0, ifc.instr_ready}, 1);
      seen = 0;
      repeat (4) begin
        @(posedge clk);
        #1;
        if (wb_valid !== 1'b0) seen = 1;
      end
      chk("no_wb_illegal", {31'd0, seen}, 0);
      check_regs();
      chk("perf_illegal", {24'd0, perf_count}, exp_perf());
      return;
    end
    chk("ready_busy", {31'd0, ifc.instr_ready}, 0);
    ref_exec(op, a, b, imm, val, c, s);
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < 8) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        chk("alu_a", {28'd0, alu_a}, a);
        chk("alu_b", {28'd0, alu_b}, b);
        chk("alu_op", {29'd0, alu_op}, {29'd0, op});
        chk("alu_ci", {31'd0, alu_ci}, (op == 3'd6 || op == 3'd7) ? 1 : 0);
      end
      if (wb_valid === 1'b1) seen = 1;
    end
    chk("wb_latency", seen ? cyc : 99, (op == 3'd3) ? 2 : 3);
    if (rd != 2'd0) m_regs[rd] = val;
    m_perf++;
    chk("flag_z", {31'd0, flag_z}, (val == 0) ? 1 : 0);
    chk("flag_c", {31'd0, flag_c}, c);
    chk("flag_s", {31'd0, flag_s}, s);
    chk("err_sticky", {31'd0, err}, m_err);
    chk("alu_zero", {31'd0, alu_zero}, 0);
    check_regs();
    chk("perf", {24'd0, perf_count}, exp_perf());
    @(posedge clk);
    #1;
    chk("wb_pulse_end", {31'd0, wb_valid}, 0);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_regs[i] = 0;
    m_perf = 0;
    m_err  = 0;
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_alu_a"}, {28'd0, alu_a}, 0);
    chk({tag, "_alu_b"}, {28'd0, alu_b}, 0);
    chk({tag, "_alu_op"}, {29'd0, alu_op}, 0);
    chk({tag, "_alu_ci"}, {31'd0, alu_ci}, 0);
    chk({tag, "_flags"}, {29'd0, flag_c, flag_s, flag_z}, 0);
    chk({tag, "_wb_valid"}, {31'd0, wb_valid}, 0);
    chk({tag, "_err"}, {31'd0, err}, 0);
    chk({tag, "_perf"}, {24'd0, perf_count}, 0);
  endtask

  initial begin
    int  sel;
    bit  seen;
    logic [2:0] rop;

    ifc.instr_valid = 1'b0;
    ifc.instr_op    = '0;
    ifc.instr_rd    = '0;
    ifc.instr_rs    = '0;
    ifc.instr_rt    = '0;
    ifc.instr_imm   = '0;
    model_reset();

    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_cleared("reset");
    chk("reset_ready", {31'd0, ifc.instr_ready}, 1);
    check_regs();

    // ADD
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd4);
    do_instr(3'd3, 2'd2, 2'd0, 2'd0, 4'd2);
    do_instr(3'd2, 2'd3, 2'd1, 2'd2, 4'd0);
    // SUB with and without borrow
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd5);
    do_instr(3'd3, 2'd2, 2'd0, 2'd0, 4'd2);
    do_instr(3'd6, 2'd3, 2'd1, 2'd2, 4'd0);
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd2);
    do_instr(3'd3, 2'd2, 2'd0, 2'd0, 4'd4);
    do_instr(3'd6, 2'd3, 2'd1, 2'd2, 4'd0);
    // SLT true, then equal operands
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd2);
    do_instr(3'd3, 2'd2, 2'd0, 2'd0, 4'd7);
    do_instr(3'd7, 2'd3, 2'd1, 2'd2, 4'd0);
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'hC);
    do_instr(3'd3, 2'd2, 2'd0, 2'd0, 4'hC);
    do_instr(3'd7, 2'd3, 2'd1, 2'd2, 4'd0);
    // logic ops, zero immediate
    do_instr(3'd0, 2'd3, 2'd1, 2'd2, 4'd0);
    do_instr(3'd1, 2'd3, 2'd1, 2'd0, 4'd0);
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd0);
    // illegal op, then ADD
    do_instr(3'd5, 2'd3, 2'd1, 2'd2, 4'd9);
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd9);
    do_instr(3'd2, 2'd3, 2'd1, 2'd2, 4'd0);
    // ADD into R0
    do_instr(3'd2, 2'd0, 2'd1, 2'd3, 4'd0);

    for (int k = 0; k < 60; k++) begin
      sel = $urandom_range(0, 9);
      if (sel < 6)       rop = legal_op(sel);
      else if (sel == 6) rop = ($urandom_range(0, 1) == 0) ? 3'd4 : 3'd5;
      else               rop = legal_op($urandom_range(0, 5));
      do_instr(rop, 2'($urandom), 2'($urandom), 2'($urandom), 4'($urandom));
    end

    // reset during EXEC drops the instruction
    do_instr(3'd3, 2'd1, 2'd0, 2'd0, 4'd7);
    ifc.instr_valid = 1'b1;
    ifc.instr_op    = 3'd2;
    ifc.instr_rd    = 2'd2;
    ifc.instr_rs    = 2'd1;
    ifc.instr_rt    = 2'd1;
    @(posedge clk);
    #1;
    ifc.instr_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    model_reset();
    check_cleared("midreset");
    check_regs();
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midreset_ready", {31'd0, ifc.instr_ready}, 1);
    seen = 0;
    repeat (4) begin
      @(posedge clk);
      #1;
      if (wb_valid !== 1'b0) seen = 1;
    end
    chk("midreset_no_wb", {31'd0, seen}, 0);
    check_regs();

    // counter saturation
    for (int k = 0; k < 260; k++) begin
      do_instr(3'd3, 2'($urandom_range(0, 3)), 2'd0, 2'd0, 4'($urandom));
    end
    chk("perf_final", {24'd0, perf_count}, exp_perf());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/alu_issue.md
# alu_issue

Sequencing front end for the 4-bit `alu`. It accepts one instruction at a time over a valid/ready handshake and reads operands from a 4-entry × 4-bit register file. It drives the `alu` operand and opcode inputs, samples its result and flags, and writes the result back. It sits directly upstream of `alu`, which is instantiated outside this block, and directly downstream of it as well, consuming `r`, `co` and `slt`.

## Interface
- `NREG`, default 4: register count; fixed at 4, with a 2-bit index.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, synchronous, active-low.
- `instr_valid`  in  1  instruction present.
- `instr_ready`  out  1  block can accept an instruction.
- `instr_op`  in  3  0 AND, 1 OR, 2 ADD, 3 LOADI, 6 SUB, 7 SLT; 4 and 5 are illegal.
- `instr_rd`, `instr_rs`, `instr_rt`  in  2 each  destination, source A and source B indices.
- `instr_imm`  in  4  immediate value for LOADI.
- `alu_a`, `alu_b`  out  4 each  registered operands to `alu`.
- `alu_op`  out  3  registered opcode to `alu`.
- `alu_ci`  out  1  carry-in to `alu`.
- `alu_zero`  out  1  tied to 0.
- `alu_r`  in  4  result from `alu`.
- `alu_co`  in  1  carry-out from `alu`.
- `alu_slt`  in  1  set-less-than from `alu`.
- `flag_c`, `flag_s`, `flag_z`  out  1 each  carry, slt and zero flags of the last retired instruction.
- `wb_valid`  out  1  one-cycle pulse on writeback.
- `err`  out  1  sticky illegal-opcode flag.
- `dbg_sel`  in  2  debug register select.
- `dbg_data`  out  4  combinational read of the selected register.
- `perf_count`  out  8  retired-instruction count; see Configuration.

## Operation
- The FSM has four states: IDLE, READ, EXEC, WB.
- **IDLE**
  - `instr_ready`=1.
  - On `instr_valid`, latch op, rd, rs, rt and imm, then go to READ.
  - If the op is illegal (4 or 5): set `err`, stay in IDLE, and discard the instruction.
- **READ**
  - Load `alu_a`=R[rs], `alu_b`=R[rt], `alu_op`=op.
  - `alu_ci`=1 for op 6 and 7, otherwise 0.
  - LOADI skips EXEC and goes directly to WB.
- **EXEC**
  - Gives `alu` one full cycle to settle.
  - At the end of the cycle, sample `alu_r`, `alu_co` and `alu_slt` into result registers.
- **WB**
  - Write the result to R[rd] and pulse `wb_valid`, then return to IDLE.
  - Value written:
    - op 7: `{3'b0, slt}`.
    - op 3: imm.
    - all other ops: `alu_r`.
  - Flag updates:
    - `flag_z` = (written value == 0).
    - `flag_c` = `alu_co`; forced to 0 for LOADI.
    - `flag_s` = `alu_slt` for op 7, otherwise 0.
- **R0** always reads as 0. Writes to R0 are discarded, but flags and `wb_valid` still update.
- **Arithmetic** is modulo 16 and wraps; there is no overflow detection.
- **Reset** (`rst_n`=0 on any edge, including mid-instruction):
  - state → IDLE; any in-flight instruction is dropped with no writeback.
  - Cleared to 0: all registers, `alu_a`, `alu_b`, `alu_op`, `alu_ci`, all flags, `wb_valid`, `err`, `perf_count`.
  - `instr_ready`=1 once `rst_n`=1.

## Timing
- Handshake fires on an edge where `instr_valid`=1 and `instr_ready`=1 (cycle 0).
- ALU ops:
  - Edge 1: READ loads the operands.
  - Edge 2: EXEC samples the result.
  - Edge 3: WB writes back; `wb_valid` is high during the cycle after edge 3.
  - Throughput: one instruction per 4 cycles.
- LOADI writes back one cycle earlier (edge 2) and can be accepted every 3 cycles.
- `instr_ready` is 0 in READ, EXEC and WB, so there is no back-to-back accept.
- A read of rd issued immediately after WB sees the new value, because the register file updates at the WB edge.
- `dbg_data` reflects a write in the cycle after the WB edge.

## Configuration
- `ALU_ISSUE_PERF_EN` defined:
  - `perf_count` increments by 1 at each WB edge and saturates at 255.
  - Illegal ops are not counted.
- `ALU_ISSUE_PERF_EN` undefined: `perf_count` is tied to 0 and no counter logic is generated.

## Structure
- Shared package `alu_pkg` holds:
  - opcode constants: `OP_AND`=0, `OP_OR`=1, `OP_ADD`=2, `OP_LOADI`=3, `OP_SUB`=6, `OP_SLT`=7;
  - the FSM state encoding;
  - the `is_legal_op` function.
- One sub-module, `alu_regfile`:
  - 4×4 storage with R0 hardwired to 0;
  - two combinational read ports plus the debug port;
  - one synchronous write port.

## Test plan
- LOADI R1=4, LOADI R2=2, then ADD R3=R1+R2 → R3=6, `flag_c`=0, `flag_z`=0, `wb_valid` 3 edges after accept.
- LOADI R1=5, R2=2, then SUB R3=R1−R2 with `alu_ci`=1 → R3=3, `flag_c`=1; repeat with R1=2, R2=4 → R3=0xE, `flag_c`=0.
- LOADI R1=2, R2=7, then SLT R3 → R3=1, `flag_s`=1; with R1=R2=0xC → R3=0, `flag_s`=0, `flag_z`=1.
- Issue op=5 → `err`=1, no `wb_valid`, registers unchanged; a following ADD completes normally.
- ADD with rd=0 → `dbg_data`(sel 0)=0 and `wb_valid` pulses; assert `rst_n`=0 during EXEC → no writeback, all outputs 0, `instr_ready`=1 after release.
- With `ALU_ISSUE_PERF_EN`: 260 LOADIs → `perf_count`=255; without the macro → `perf_count`=0 throughout.
